// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple-carry adder: one W-bit slice per stage, carry and unconsumed
// operand bits travel down the pipe with the partial sum. Valid/ready on both sides.
module adder_pipe_nbit #(
  parameter int BIT_WIDTH = 16,
  parameter int STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = BIT_WIDTH / STAGES;

  if (BIT_WIDTH < 2 || STAGES < 1 || (BIT_WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe_nbit: BIT_WIDTH must be >= 2 and an integer multiple of STAGES");
  end

  function automatic logic [W:0] add_slice(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  logic                 advance;
  logic [BIT_WIDTH-1:0] a_q   [STAGES];
  logic [BIT_WIDTH-1:0] a_d   [STAGES];
  logic [BIT_WIDTH-1:0] b_q   [STAGES];
  logic [BIT_WIDTH-1:0] b_d   [STAGES];
  logic [BIT_WIDTH-1:0] sum_q [STAGES];
  logic [BIT_WIDTH-1:0] sum_d [STAGES];
  logic                 carry_q [STAGES];
  logic                 carry_d [STAGES];
  logic                 valid_q [STAGES];
  logic                 valid_d [STAGES];

  logic [BIT_WIDTH-1:0] in_a   [STAGES];
  logic [BIT_WIDTH-1:0] in_b   [STAGES];
  logic [BIT_WIDTH-1:0] in_sum [STAGES];
  logic                 in_c   [STAGES];
  logic                 in_v   [STAGES];
  logic [W:0]           slice;

  // Operands are kept right-aligned: each stage shifts out the slice it consumed,
  // so the next stage always adds bits [W-1:0] of what it receives.
  always_comb begin
    advance = !valid_q[STAGES-1] || out_ready;
    slice   = '0;
    in_a[0]   = a;
    in_b[0]   = b;
    in_sum[0] = '0;
    in_c[0]   = carry_in;
    in_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_a[k]   = a_q[k-1];
      in_b[k]   = b_q[k-1];
      in_sum[k] = sum_q[k-1];
      in_c[k]   = carry_q[k-1];
      in_v[k]   = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
      valid_d[k] = valid_q[k];
      if (advance) begin
        slice      = add_slice(in_a[k][W-1:0], in_b[k][W-1:0], in_c[k]);
        a_d[k]     = in_a[k] >> W;
        b_d[k]     = in_b[k] >> W;
        sum_d[k]   = in_sum[k] | (BIT_WIDTH'(slice[W-1:0]) << (k * W));
        carry_d[k] = slice[W];
        valid_d[k] = in_v[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        valid_q[k] <= valid_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign sum       = sum_q[STAGES-1];
  assign overflow  = carry_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];

  a_operands_known: assert property (@(posedge clk) in_valid |-> !$isunknown({a, b, carry_in}));

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit: three instances (16/4, 32/8, 8/1) sharing
// clock and reset, each checked against hand-computed values and a scoreboard.
module tb_adder_pipe_nbit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a0, b0, sum0;
  logic        cin0, iv0, ir0, ovf0, ov0, or0;
  logic [31:0] a1, b1, sum1;
  logic        cin1, iv1, ir1, ovf1, ov1, or1;
  logic [7:0]  a2, b2, sum2;
  logic        cin2, iv2, ir2, ovf2, ov2, or2;

  adder_pipe_nbit #(.BIT_WIDTH(16), .STAGES(4)) dut0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .carry_in(cin0), .in_valid(iv0), .in_ready(ir0),
    .sum(sum0), .overflow(ovf0), .out_valid(ov0), .out_ready(or0));
  adder_pipe_nbit #(.BIT_WIDTH(32), .STAGES(8)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(cin1), .in_valid(iv1), .in_ready(ir1),
    .sum(sum1), .overflow(ovf1), .out_valid(ov1), .out_ready(or1));
  adder_pipe_nbit #(.BIT_WIDTH(8), .STAGES(1)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .carry_in(cin2), .in_valid(iv2), .in_ready(ir2),
    .sum(sum2), .overflow(ovf2), .out_valid(ov2), .out_ready(or2));

  int checks = 0;
  int fails  = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int widthOf(input int d);
    return (d == 0) ? 16 : (d == 1) ? 32 : 8;
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 1;
  endfunction

  function automatic logic outValid(input int d);
    return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
  endfunction

  function automatic logic inReady(input int d);
    return (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
  endfunction

  function automatic logic [32:0] outRes(input int d);
    if (d == 0) return {ovf0, 16'h0, sum0};
    if (d == 1) return {ovf1, sum1};
    return {ovf2, 24'h0, sum2};
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  // Reference: full-precision add, then split into carry-out and wrapped sum.
  function automatic logic [32:0] addModel(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic c);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, x} + {1'b0, y} + {32'h0, c};
    m = (33'h1 << w) - 33'h1;
    return {s[w], s[31:0] & m[31:0]};
  endfunction

  task automatic driveIn(input int d, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic v);
    case (d)
      0: begin a0 = x[15:0]; b0 = y[15:0]; cin0 = c; iv0 = v; end
      1: begin a1 = x;       b1 = y;       cin1 = c; iv1 = v; end
      default: begin a2 = x[7:0]; b2 = y[7:0]; cin2 = c; iv2 = v; end
    endcase
  endtask

  task automatic applyStimulus(input int d, input logic [31:0] x, input logic [31:0] y,
                               input logic c, input logic [32:0] e);
    driveIn(d, x, y, c, 1'b1);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    driveIn(d, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic checkPop(input int d);
    logic [32:0] e;
    logic        empty;
    e = '0;
    empty = (qSize(d) == 0);
    if (!empty) begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
    if (empty) checkOutput($sformatf("spurious_out_%0d", d), 64'd1, 64'd0);
    else       checkOutput($sformatf("result_%0d", d), 64'(outRes(d)), 64'(e));
  endtask

  // Every output transfer is checked against the head of that instance's scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ov0 && or0) checkPop(0);
      if (ov1 && or1) checkPop(1);
      if (ov2 && or2) checkPop(2);
    end
  end

  task automatic singleAdd(input int d, input logic [31:0] x, input logic [31:0] y,
                           input logic c, input logic [31:0] es, input logic eo,
                           input string tag);
    applyStimulus(d, x, y, c, {eo, es});
    driveIn(d, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < latOf(d); i++) begin
      checkOutput({tag, "_early"}, 64'(outValid(d)), 64'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_valid"}, 64'(outValid(d)), 64'd1);
    checkOutput({tag, "_result"}, 64'(outRes(d)), 64'({eo, es}));
    @(posedge clk); #1;
    checkOutput({tag, "_oneshot"}, 64'(outValid(d)), 64'd0);
  endtask

  task automatic streamTest(input int d);
    logic [31:0] m;
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    m = (widthOf(d) == 32) ? 32'hFFFF_FFFF : ((32'h1 << widthOf(d)) - 32'h1);
    for (int i = 0; i < 8; i++) begin
      x = $urandom & m;
      y = $urandom & m;
      c = 1'($urandom_range(0, 1));
      checkOutput($sformatf("stream_in_ready_%0d", d), 64'(inReady(d)), 64'd1);
      applyStimulus(d, x, y, c, addModel(widthOf(d), x, y, c));
    end
    idle(d, latOf(d) + 2);
    checkOutput($sformatf("stream_drained_%0d", d), 64'(qSize(d)), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    driveIn(0, 32'h0, 32'h0, 1'b0, 1'b0);
    driveIn(1, 32'h0, 32'h0, 1'b0, 1'b0);
    driveIn(2, 32'h0, 32'h0, 1'b0, 1'b0);
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_out_valid_%0d", d), 64'(outValid(d)), 64'd0);
      checkOutput($sformatf("reset_result_%0d", d), 64'(outRes(d)), 64'd0);
      checkOutput($sformatf("reset_in_ready_%0d", d), 64'(inReady(d)), 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_out_valid", 64'({ov0, ov1, ov2}), 64'd0);
    end

    singleAdd(0, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, "w16_single");
    singleAdd(0, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, "w16_carry_all");
    singleAdd(0, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, "w16_carry_slice");
    singleAdd(0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, "w16_msb");
    streamTest(0);

    // Fill the 16-bit pipe with the output blocked, then hold and release.
    or0 = 1'b0;
    applyStimulus(0, 32'h1111, 32'h2222, 1'b0, {1'b0, 32'h3333});
    applyStimulus(0, 32'h8000, 32'h8000, 1'b0, {1'b1, 32'h0000});
    applyStimulus(0, 32'hABCD, 32'h1234, 1'b1, {1'b0, 32'hBE02});
    applyStimulus(0, 32'hFFFE, 32'h0001, 1'b1, {1'b1, 32'h0000});
    driveIn(0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("stall_out_valid", 64'(ov0), 64'd1);
      checkOutput("stall_in_ready", 64'(ir0), 64'd0);
      checkOutput("stall_result", 64'(outRes(0)), 64'h3333);
      if (i < 5) begin @(posedge clk); #1; end
    end
    or0 = 1'b1;
    idle(0, 6);
    checkOutput("stall_drained", 64'(q0.size()), 64'd0);

    // Reset with three transactions in flight; none may surface afterwards.
    applyStimulus(0, 32'h0101, 32'h0202, 1'b0, {1'b0, 32'h0303});
    applyStimulus(0, 32'h0404, 32'h0505, 1'b0, {1'b0, 32'h0909});
    applyStimulus(0, 32'h0606, 32'h0707, 1'b0, {1'b0, 32'h0D0D});
    rst = 1'b1;
    driveIn(0, 32'h0, 32'h0, 1'b0, 1'b0);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_in_ready", 64'(ir0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("midreset_out_valid", 64'(ov0), 64'd0);
      @(posedge clk); #1;
    end

    singleAdd(1, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, "w32_single");
    singleAdd(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, "w32_carry_all");
    singleAdd(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, "w32_carry_slice");
    streamTest(1);

    singleAdd(2, 32'h12, 32'h43, 1'b0, 32'h55, 1'b0, "w8_single");
    singleAdd(2, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, "w8_carry_all");
    singleAdd(2, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, "w8_carry_nibble");
    streamTest(2);

    idle(0, 2);
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("final_queue_empty_%0d", d), 64'(qSize(d)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
